user_pass_controller: RTL and testbench

- Downstream of the user-ID check: once the ID stage asserts pass_allow, this block collects a 16-bit password word from the braille entry path.
- Compares the entry against the stored password for the same user slot, held in a synchronous 8-entry password ROM.
- Grants login on a match; counts failed attempts and locks out after too many.
- Result drives the trainer's session start.

---
 rtl/user_pass_controller.sv | 139 +++++++++++++
 tb/tb_user_pass_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_pass_controller.sv
// Password stage of the braille trainer login: fetches the stored word for the
// identified user slot, compares it against the entry, and manages retries/lockout.
module user_pass_controller #(
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pass_allow,
    input  logic [2:0]  address_user,
    input  logic [15:0] pass_entry,
    input  logic        pass_valid,
    input  logic [15:0] q_pass,
    output logic [2:0]  address_pass,
    output logic        login_ok,
    output logic        login_fail,
    output logic        locked,
    output logic [2:0]  attempts
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ENTRY,
        FETCH,
        COMPARE,
        GRANTED,
        LOCKED
    } state_t;

    localparam logic [2:0]  MaxAtt   = 3'(MAX_ATTEMPTS);
    localparam logic [15:0] LockLoad = 16'(LOCK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] entry_q, entry_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  att_q, att_d;
    logic        ok_q, ok_d;
    logic        fail_q, fail_d;
    logic        lock_q, lock_d;
    logic [2:0]  att_inc;

    assign att_inc = att_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            entry_q <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        fail_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // pass_valid is deliberately ignored here, even on the rise
                if (pass_allow) begin
                    addr_d  = address_user;
                    att_d   = '0;
                    state_d = WAIT_ENTRY;
                end
            end
            WAIT_ENTRY: begin
                if (!pass_allow) begin
                    state_d = IDLE;
                end else if (pass_valid) begin
                    entry_d = pass_entry;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = pass_allow ? COMPARE : IDLE;
            end
            COMPARE: begin
                if (!pass_allow) begin
                    state_d = IDLE;
                end else if (entry_q == q_pass) begin
                    state_d = GRANTED;
                end else begin
                    fail_d = 1'b1;
                    if (att_inc >= MaxAtt) begin
                        att_d   = MaxAtt;
                        cnt_d   = LockLoad;
                        state_d = LOCKED;
                    end else begin
                        att_d   = att_inc;
                        state_d = WAIT_ENTRY;
                    end
                end
            end
            GRANTED: begin
                if (!pass_allow) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                // only rst leaves early; inputs are ignored for the full window
                if (cnt_q == '0) begin
                    att_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ok_d   = (state_d == GRANTED);
        lock_d = (state_d == LOCKED);
    end

    assign address_pass = addr_q;
    assign login_ok     = ok_q;
    assign login_fail   = fail_q;
    assign locked       = lock_q;
    assign attempts     = att_q;

endmodule

// File: tb/tb_user_pass_controller.sv
// Directed bench for user_pass_controller with a behavioural password ROM
// (ROM[i] = 16'hCCC0 | i) and a short lockout window.
module tb_user_pass_controller;

    logic        clk;
    logic        rst;
    logic        pass_allow;
    logic [2:0]  address_user;
    logic [15:0] pass_entry;
    logic        pass_valid;
    logic [15:0] q_pass;
    logic [2:0]  address_pass;
    logic        login_ok;
    logic        login_fail;
    logic        locked;
    logic [2:0]  attempts;

    int checks;
    int failures;

    user_pass_controller #(
        .MAX_ATTEMPTS(3),
        .LOCK_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pass_allow  (pass_allow),
        .address_user(address_user),
        .pass_entry  (pass_entry),
        .pass_valid  (pass_valid),
        .q_pass      (q_pass),
        .address_pass(address_pass),
        .login_ok    (login_ok),
        .login_fail  (login_fail),
        .locked      (locked),
        .attempts    (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        q_pass <= 16'hCCC0 | {13'd0, address_pass};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // strobe one entry, then wait until the result edge (3rd edge)
    task automatic enter(input logic [15:0] w);
        pass_entry = w;
        pass_valid = 1'b1;
        tick();
        pass_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (address_pass !== 3'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d exp=0", address_pass);
        end
        checks++;
        if ({login_ok, login_fail, locked} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000",
                     {login_ok, login_fail, locked});
        end
        checks++;
        if (attempts !== 3'd0) begin
            failures++;
            $display("FAIL reset_att got=%0d exp=0", attempts);
        end
    endtask

    task automatic test_grant();
        pass_allow   = 1'b1;
        address_user = 3'd3;
        tick();
        checks++;
        if (address_pass !== 3'd3) begin
            failures++;
            $display("FAIL grant_addr got=%0d exp=3", address_pass);
        end
        pass_entry = 16'hCCC3;
        pass_valid = 1'b1;
        tick();
        pass_valid = 1'b0;
        tick();
        checks++;
        if (login_ok !== 1'b0) begin
            failures++;
            $display("FAIL grant_early got=%b exp=0", login_ok);
        end
        tick();
        checks++;
        if (login_ok !== 1'b1) begin
            failures++;
            $display("FAIL grant_ok got=%b exp=1", login_ok);
        end
        checks++;
        if (attempts !== 3'd0) begin
            failures++;
            $display("FAIL grant_att got=%0d exp=0", attempts);
        end
        pass_allow = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_retry();
        pass_allow   = 1'b1;
        address_user = 3'd3;
        tick();
        pass_entry = 16'h0000;
        pass_valid = 1'b1;
        tick();
        pass_valid = 1'b0;
        tick();
        checks++;
        if (login_fail !== 1'b0) begin
            failures++;
            $display("FAIL retry_fail_early got=%b exp=0", login_fail);
        end
        tick();
        checks++;
        if (login_fail !== 1'b1 || attempts !== 3'd1) begin
            failures++;
            $display("FAIL retry_fail got=%b/%0d exp=1/1", login_fail, attempts);
        end
        tick();
        checks++;
        if (login_fail !== 1'b0) begin
            failures++;
            $display("FAIL retry_pulse got=%b exp=0", login_fail);
        end
        enter(16'hCCC3);
        checks++;
        if (login_ok !== 1'b1 || attempts !== 3'd1) begin
            failures++;
            $display("FAIL retry_ok got=%b/%0d exp=1/1", login_ok, attempts);
        end
        pass_allow = 1'b0;
        tick();
        checks++;
        if (login_ok !== 1'b0) begin
            failures++;
            $display("FAIL retry_drop got=%b exp=0", login_ok);
        end
        // IDLE re-latches the slot on the next allow
        address_user = 3'd2;
        pass_allow   = 1'b1;
        tick();
        checks++;
        if (address_pass !== 3'd2 || attempts !== 3'd0) begin
            failures++;
            $display("FAIL retry_idle got=%0d/%0d exp=2/0", address_pass, attempts);
        end
        pass_allow = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        pass_allow   = 1'b1;
        address_user = 3'd3;
        tick();
        for (int k = 1; k <= 3; k++) begin
            enter(16'h1234);
            checks++;
            if (login_fail !== 1'b1 || attempts !== 3'(k)) begin
                failures++;
                $display("FAIL lock_fail%0d got=%b/%0d exp=1/%0d",
                         k, login_fail, attempts, k);
            end
            checks++;
            if (locked !== (k == 3)) begin
                failures++;
                $display("FAIL lock_flag%0d got=%b exp=%b", k, locked, k == 3);
            end
        end
        for (int i = 1; i <= 7; i++) begin
            if (i == 2) begin
                pass_entry = 16'hCCC3;
                pass_valid = 1'b1;
            end
            tick();
            pass_valid = 1'b0;
            checks++;
            if (locked !== 1'b1 || login_ok !== 1'b0 || login_fail !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold%0d got=%b%b%b exp=100",
                         i, locked, login_ok, login_fail);
            end
        end
        tick();
        checks++;
        if (locked !== 1'b0 || attempts !== 3'd0) begin
            failures++;
            $display("FAIL lock_exit got=%b/%0d exp=0/0", locked, attempts);
        end
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (login_ok !== 1'b0) begin
            failures++;
            $display("FAIL lock_ignored got=%b exp=0", login_ok);
        end
        pass_allow = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        pass_allow   = 1'b1;
        address_user = 3'd3;
        tick();
        enter(16'h0001);
        pass_entry = 16'h0002;
        pass_valid = 1'b1;
        tick();
        pass_valid = 1'b0;
        pass_allow = 1'b0;
        tick();
        checks++;
        if (login_fail !== 1'b0) begin
            failures++;
            $display("FAIL abort_fetch_fail got=%b exp=0", login_fail);
        end
        tick();
        checks++;
        if (login_fail !== 1'b0 || login_ok !== 1'b0 || attempts !== 3'd1) begin
            failures++;
            $display("FAIL abort_fetch got=%b%b/%0d exp=00/1",
                     login_fail, login_ok, attempts);
        end
        address_user = 3'd6;
        pass_allow   = 1'b1;
        tick();
        checks++;
        if (address_pass !== 3'd6 || attempts !== 3'd0) begin
            failures++;
            $display("FAIL abort_idle got=%0d/%0d exp=6/0", address_pass, attempts);
        end
        pass_entry = 16'h0003;
        pass_valid = 1'b1;
        tick();
        pass_valid = 1'b0;
        tick();
        pass_allow = 1'b0;
        tick();
        checks++;
        if (login_fail !== 1'b0 || attempts !== 3'd0) begin
            failures++;
            $display("FAIL abort_cmp got=%b/%0d exp=0/0", login_fail, attempts);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pass_allow   = 1'b1;
        address_user = 3'd4;
        tick();
        enter(16'hCCC4);
        checks++;
        if (login_ok !== 1'b1) begin
            failures++;
            $display("FAIL rstg_ok got=%b exp=1", login_ok);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (login_ok !== 1'b0 || address_pass !== 3'd0 || attempts !== 3'd0) begin
            failures++;
            $display("FAIL rstg got=%b/%0d/%0d exp=0/0/0",
                     login_ok, address_pass, attempts);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            enter(16'hBEEF);
        end
        tick();
        tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL rstl_locked got=%b exp=1", locked);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({locked, login_ok, login_fail} !== 3'b000 ||
            attempts !== 3'd0 || address_pass !== 3'd0) begin
            failures++;
            $display("FAIL rstl got=%b%b%b/%0d/%0d exp=000/0/0",
                     locked, login_ok, login_fail, attempts, address_pass);
        end
        pass_allow = 1'b0;
        tick();
    endtask

    task automatic test_readdr();
        pass_allow   = 1'b1;
        address_user = 3'd5;
        tick();
        address_user = 3'd1;
        tick();
        checks++;
        if (address_pass !== 3'd5) begin
            failures++;
            $display("FAIL readdr_hold got=%0d exp=5", address_pass);
        end
        enter(16'hCCC5);
        checks++;
        if (login_ok !== 1'b1 || login_fail !== 1'b0) begin
            failures++;
            $display("FAIL readdr_rom5 got=%b%b exp=10", login_ok, login_fail);
        end
        pass_allow = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        pass_allow   = 1'b1;
        address_user = 3'd2;
        pass_entry   = 16'hCCC2;
        pass_valid   = 1'b1;
        tick();
        pass_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (login_ok !== 1'b0 || login_fail !== 1'b0) begin
            failures++;
            $display("FAIL b2b_rise got=%b%b exp=00", login_ok, login_fail);
        end
        enter(16'hCCC2);
        checks++;
        if (login_ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ok got=%b exp=1", login_ok);
        end
        pass_allow = 1'b0;
        tick();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        pass_allow   = 1'b0;
        address_user = 3'd0;
        pass_entry   = 16'd0;
        pass_valid   = 1'b0;
        test_reset();
        test_grant();
        test_retry();
        test_lockout();
        test_abort();
        test_reset_mid();
        test_readdr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
